// File: rtl/vex_pipe.sv
// vex_pipe: one-lane execution sequencer tracking ALU/multiplier completions into one registered
// writeback per cycle. Define VEX_PIPE_PERF_EN to add the retired/stall/mul performance counters.
module vex_pipe #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_BITS   = 5,
    parameter int MUL_LATENCY = 3,
    parameter int IN_ORDER    = 1,
    parameter int LANE_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic                  i_in_is_mul,
    input  logic [DEST_BITS-1:0]  i_in_dest,
    input  logic [2:0]            i_in_sew,
    input  logic [DATA_WIDTH-1:0] i_in_operand_3,
    output logic                  o_fu_dispatch,
    output logic                  o_fu_mul_dispatch,
    input  logic [DATA_WIDTH-1:0] i_fu_result,
    input  logic                  i_fu_mask_wb,
    input  logic [DATA_WIDTH-1:0] i_mul_result,
    input  logic                  i_mul_mask_wb,
    input  logic                  i_wait_load_in,
    input  logic [4:0]            i_load_dest_in,
    output logic                  o_wb_valid,
    output logic [DEST_BITS-1:0]  o_wb_dest,
    output logic [2:0]            o_wb_sew,
    output logic [DATA_WIDTH-1:0] o_wb_result,
    output logic                  o_wb_mask_wb,
    output logic [DATA_WIDTH-1:0] o_wb_operand_3,
    output logic                  o_wait_load_out,
    output logic [4:0]            o_load_dest_out
`ifdef VEX_PIPE_PERF_EN
    ,
    output logic [31:0]           o_perf_retired,
    output logic [31:0]           o_perf_stall,
    output logic [31:0]           o_perf_mul
`endif
);
    localparam int L = MUL_LATENCY;

    // Slot k holds the packet whose result arrives k cycles from now.
    logic [L-1:0]          r_vld;
    logic [L-1:0]          r_mul;
    logic [DEST_BITS-1:0]  r_dest [L];
    logic [2:0]            r_sew  [L];
    logic [DATA_WIDTH-1:0] r_op3  [L];
    logic                  w_hazard;
    logic                  w_alu_acc;
    logic                  w_mul_acc;

    // Only muls can sit above slot 0, so in-order mode just waits for all of them to reach slot 0.
    always_comb begin
        w_hazard   = (IN_ORDER != 0) ? |r_vld[L-1:1] : r_vld[1];
        o_in_ready = i_in_is_mul | ~w_hazard;
        w_alu_acc  = i_in_valid & o_in_ready & ~i_in_is_mul;
        w_mul_acc  = i_in_valid & o_in_ready & i_in_is_mul;
    end

    assign o_fu_dispatch     = w_alu_acc;
    assign o_fu_mul_dispatch = w_mul_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_mul <= '0;
            for (int k = 0; k < L; k++) begin
                r_dest[k] <= '0;
                r_sew[k]  <= '0;
                r_op3[k]  <= '0;
            end
        end else begin
            r_vld <= {1'b0, r_vld[L-1:1]};
            r_mul <= {1'b0, r_mul[L-1:1]};
            for (int k = 0; k < L-1; k++) begin
                r_dest[k] <= r_dest[k+1];
                r_sew[k]  <= r_sew[k+1];
                r_op3[k]  <= r_op3[k+1];
            end
            if (w_alu_acc) begin
                r_vld[0]  <= 1'b1;
                r_mul[0]  <= 1'b0;
                r_dest[0] <= i_in_dest;
                r_sew[0]  <= i_in_sew;
                r_op3[0]  <= i_in_operand_3;
            end
            if (w_mul_acc) begin
                r_vld[L-1]  <= 1'b1;
                r_mul[L-1]  <= 1'b1;
                r_dest[L-1] <= i_in_dest;
                r_sew[L-1]  <= i_in_sew;
                r_op3[L-1]  <= i_in_operand_3;
            end
        end
    end

    // Writeback data holds its last value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_valid     <= 1'b0;
            o_wb_dest      <= '0;
            o_wb_sew       <= '0;
            o_wb_result    <= '0;
            o_wb_mask_wb   <= 1'b0;
            o_wb_operand_3 <= '0;
        end else begin
            o_wb_valid <= r_vld[0];
            if (r_vld[0]) begin
                o_wb_dest      <= r_dest[0];
                o_wb_sew       <= r_sew[0];
                o_wb_result    <= r_mul[0] ? i_mul_result : i_fu_result;
                o_wb_mask_wb   <= r_mul[0] ? i_mul_mask_wb : i_fu_mask_wb;
                o_wb_operand_3 <= r_op3[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wait_load_out <= 1'b0;
            o_load_dest_out <= '0;
        end else begin
            o_wait_load_out <= i_wait_load_in;
            o_load_dest_out <= i_load_dest_in;
        end
    end

`ifdef VEX_PIPE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_retired <= '0;
            o_perf_stall   <= '0;
            o_perf_mul     <= '0;
        end else begin
            o_perf_retired <= o_perf_retired + 32'(o_wb_valid);
            o_perf_stall   <= o_perf_stall + 32'(i_in_valid & ~o_in_ready);
            o_perf_mul     <= o_perf_mul + 32'(w_mul_acc);
        end
    end
`endif

    a_slot_collision: assert property (@(posedge clk) disable iff (rst) !(w_alu_acc && r_vld[1]))
        else $error("vex_pipe lane %0d: two results aimed at the same slot", LANE_ID);

endmodule
